// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: datapath width, opcodes
// and the FSM state encoding.
package alu_arbiter_pkg;

    localparam int WIDTH = 16;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_PASSB = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_BSWAP = 3'd3;
    localparam logic [2:0] OP_SHL   = 3'd4;
    localparam logic [2:0] OP_SUB   = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared 16-bit ALU. Purely combinational; the clock port exists only so the
// instance matches the existing ALU footprint.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = WIDTH
) (
    input  logic              clk,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] out,
    output logic              zero,
    output logic              equal
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int HALF = DATA_W / 2;

    logic unused_clk;
    assign unused_clk = clk;

    // Opcode decode; any shift amount of DATA_W or more shifts everything out.
    always_comb begin
        out = '0;
        case (op)
            OP_AND:   out = a & b;
            OP_PASSB: out = b;
            OP_ADD:   out = a + b;
            OP_BSWAP: out = {a[HALF-1:0], b[DATA_W-1:HALF]};
            OP_SHL: begin
                if (a[DATA_W-1:SH_W] != '0)
                    out = '0;
                else
                    out = b << a[SH_W-1:0];
            end
            OP_SUB:   out = a - b;
            default:  out = '0;
        endcase
    end

    assign zero  = (out == '0);
    assign equal = (a == b);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for the shared ALU. One operation in flight:
// operands are latched at grant, the ALU result is latched one cycle later and
// held until the owning port takes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [2:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [2:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_equal,
    output logic              busy
);

    state_t            state;
    logic              pri;
    logic              owner;
    logic              any_valid;
    logic              win;
    logic              grant;
    logic              owner_ready;

    logic [2:0]        op_p0;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;

    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;
    logic              alu_equal;

    logic [DATA_W-1:0] res_p1;
    logic              zero_p1;
    logic              equal_p1;

    // Arbitration: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        win       = (req0_valid & req1_valid) ? pri : ~req0_valid;
        grant     = (state == IDLE) & any_valid;
    end

    assign req0_ready  = grant & ~win;
    assign req1_ready  = grant & win;
    assign owner_ready = owner ? rsp1_ready : rsp0_ready;

    // Stage 0: operand capture at the grant edge (data only, no reset needed).
    always_ff @(posedge clk) begin
        if (grant) begin
            op_p0 <= win ? req1_op : req0_op;
            a_p0  <= win ? req1_a  : req0_a;
            b_p0  <= win ? req1_b  : req0_b;
        end
    end

    alu_arbiter_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .clk   (clk),
        .op    (op_p0),
        .a     (a_p0),
        .b     (b_p0),
        .out   (alu_out),
        .zero  (alu_zero),
        .equal (alu_equal)
    );

    // Stage 1: control FSM with the result registers; reset drops any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pri      <= 1'b0;
            owner    <= 1'b0;
            res_p1   <= '0;
            zero_p1  <= 1'b0;
            equal_p1 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner <= win;
                        pri   <= ~win;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_p1   <= alu_out;
                    zero_p1  <= alu_zero;
                    equal_p1 <= alu_equal;
                    state    <= RESP;
                end
                RESP: begin
                    if (owner_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp0_valid = (state == RESP) & ~owner;
    assign rsp1_valid = (state == RESP) & owner;
    assign rsp_data   = res_p1;
    assign rsp_zero   = zero_p1;
    assign rsp_equal  = equal_p1;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic against a behavioural model of the arbitration and ALU rules.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_zero, rsp_equal, busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic mpri    = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_equal  (rsp_equal),
        .busy       (busy)
    );

    // Reference ALU written from the opcode table with plain integer math.
    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        longint ia, ib, r;
        ia = a;
        ib = b;
        case (op)
            3'd0:    r = ia & ib;
            3'd1:    r = ib;
            3'd2:    r = (ia + ib) % 65536;
            3'd3:    r = (ia % 256) * 256 + ib / 256;
            3'd4:    r = (ia >= 16) ? 0 : (ib * (longint'(1) << ia)) % 65536;
            3'd5:    r = (ia - ib + 65536) % 65536;
            default: r = 0;
        endcase
        return 16'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int p, input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        if (p == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic set_rsp_ready(input int p, input logic v);
        if (p == 0) rsp0_ready = v;
        else        rsp1_ready = v;
    endtask

    function automatic logic port_ready(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic port_rsp(input int p);
        return (p == 0) ? rsp0_valid : rsp1_valid;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        drive_req(0, 1'b0, 3'd0, 16'h0, 16'h0);
        drive_req(1, 1'b0, 3'd0, 16'h0, 16'h0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        mpri = 1'b0;
    endtask

    // Issue one uncontended operation and return what came back and the latency.
    task automatic run_one(input int p, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] d, output logic z, output logic e, output int lat);
        int waited;
        d = '0; z = 1'b0; e = 1'b0; lat = 0;
        drive_req(p, 1'b1, op, a, b);
        #1;
        waited = 0;
        while (!port_ready(p) && waited < 10) begin
            tick();
            waited++;
        end
        if (!port_ready(p)) begin
            n_tests++; n_fail++;
            $display("FAIL run_one_grant_timeout: port %0d never granted", p);
            drive_req(p, 1'b0, op, a, b);
            return;
        end
        tick();
        drive_req(p, 1'b0, op, a, b);
        mpri = (p == 0);
        lat = 1;
        while (!port_rsp(p) && lat < 10) begin
            tick();
            lat++;
        end
        d = rsp_data; z = rsp_zero; e = rsp_equal;
        set_rsp_ready(p, 1'b1);
        tick();
        set_rsp_ready(p, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_tests++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_equal, busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_equal, busy});
        end
        n_tests++;
        if (rsp_data !== 16'h0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0000", rsp_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        mpri = 1'b0;
    endtask

    task automatic test_single();
        drive_req(0, 1'b1, 3'd2, 16'h0003, 16'h0004);
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        drive_req(0, 1'b0, 3'd2, 16'h0003, 16'h0004);
        mpri = 1'b1;
        n_tests++;
        if ({busy, rsp0_valid} !== 2'b10) begin
            n_fail++; $display("FAIL single_exec: busy,rsp0_valid got %b want 10", {busy, rsp0_valid});
        end
        tick();
        n_tests++;
        if ({rsp0_valid, rsp1_valid, rsp_data, rsp_zero, rsp_equal} !== {2'b10, 16'h0007, 2'b00}) begin
            n_fail++;
            $display("FAIL single_rsp: got v=%b%b d=%h z=%b e=%b want v=10 d=0007 z=0 e=0",
                     rsp0_valid, rsp1_valid, rsp_data, rsp_zero, rsp_equal);
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        n_tests++;
        if ({rsp0_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL single_done: rsp0_valid,busy got %b want 00", {rsp0_valid, busy});
        end
    endtask

    task automatic test_contention();
        do_reset();
        drive_req(0, 1'b1, 3'd5, 16'h1234, 16'h1234);
        drive_req(1, 1'b1, 3'd1, 16'h0000, 16'hBEEF);
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL cont_first: got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        drive_req(0, 1'b0, 3'd5, 16'h1234, 16'h1234);
        n_tests++;
        if (req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL cont_exec_block: req1_ready got %b want 0", req1_ready);
        end
        tick();
        n_tests++;
        if ({rsp0_valid, rsp_data, rsp_zero, rsp_equal} !== {1'b1, 16'h0000, 2'b11}) begin
            n_fail++;
            $display("FAIL cont_rsp0: got v=%b d=%h z=%b e=%b want v=1 d=0000 z=1 e=1",
                     rsp0_valid, rsp_data, rsp_zero, rsp_equal);
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_fail++; $display("FAIL cont_second: got %b want 01", {req0_ready, req1_ready});
        end
        tick();
        drive_req(1, 1'b0, 3'd1, 16'h0000, 16'hBEEF);
        tick();
        n_tests++;
        if ({rsp1_valid, rsp0_valid, rsp_data, rsp_zero, rsp_equal} !== {2'b10, 16'hBEEF, 2'b00}) begin
            n_fail++;
            $display("FAIL cont_rsp1: got v1=%b v0=%b d=%h z=%b e=%b want v1=1 v0=0 d=beef z=0 e=0",
                     rsp1_valid, rsp0_valid, rsp_data, rsp_zero, rsp_equal);
        end
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        drive_req(0, 1'b1, 3'd0, 16'hF0F0, 16'h0FF0);
        drive_req(1, 1'b1, 3'd0, 16'h1111, 16'h1111);
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL cont_third: got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        drive_req(0, 1'b0, 3'd0, 16'hF0F0, 16'h0FF0);
        drive_req(1, 1'b0, 3'd0, 16'h1111, 16'h1111);
        tick();
        n_tests++;
        if (rsp_data !== 16'h00F0) begin
            n_fail++; $display("FAIL cont_third_data: got %h want 00f0", rsp_data);
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        mpri = 1'b1;
    endtask

    task automatic test_backpressure();
        drive_req(1, 1'b1, 3'd1, 16'h0000, 16'h5A5A);
        #1;
        n_tests++;
        if (req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_grant1: req1_ready got %b want 1", req1_ready);
        end
        tick();
        drive_req(1, 1'b0, 3'd1, 16'h0000, 16'h5A5A);
        mpri = 1'b0;
        drive_req(0, 1'b1, 3'd2, 16'h0001, 16'h0002);
        tick();
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if ({rsp1_valid, rsp_data, req0_ready} !== {1'b1, 16'h5A5A, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v1=%b d=%h r0=%b want v1=1 d=5a5a r0=0",
                         k, rsp1_valid, rsp_data, req0_ready);
            end
            tick();
        end
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: req0_ready got %b want 1", req0_ready);
        end
        tick();
        drive_req(0, 1'b0, 3'd2, 16'h0001, 16'h0002);
        mpri = 1'b1;
        tick();
        n_tests++;
        if ({rsp0_valid, rsp_data} !== {1'b1, 16'h0003}) begin
            n_fail++; $display("FAIL bp_rsp0: got v=%b d=%h want v=1 d=0003", rsp0_valid, rsp_data);
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
    endtask

    task automatic test_edge_ops();
        logic [2:0]  ops [5] = '{3'd4, 3'd3, 3'd2, 3'd7, 3'd4};
        logic [15:0] as  [5] = '{16'd16, 16'h12AB, 16'h8000, 16'h1234, 16'd15};
        logic [15:0] bs  [5] = '{16'hFFFF, 16'hCD34, 16'h8000, 16'h5678, 16'h0003};
        logic [15:0] d, exp;
        logic        z, e;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_one(0, ops[i], as[i], bs[i], d, z, e, lat);
            exp = ref_alu(ops[i], as[i], bs[i]);
            n_tests++;
            if ({d, z, e} !== {exp, exp == 16'h0, as[i] == bs[i]} || lat != 2) begin
                n_fail++;
                $display("FAIL edge_op%0d: got d=%h z=%b e=%b lat=%0d want d=%h z=%b e=%b lat=2",
                         i, d, z, e, lat, exp, exp == 16'h0, as[i] == bs[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        logic        z, e;
        int          lat;
        // Leave a nonzero result behind, then reset while the next op is in EXEC.
        run_one(0, 3'd2, 16'h0001, 16'h0001, d, z, e, lat);
        drive_req(0, 1'b1, 3'd2, 16'h0005, 16'h0005);
        tick();
        drive_req(0, 1'b0, 3'd2, 16'h0005, 16'h0005);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rsp_data, rsp0_valid, rsp1_valid, rsp_zero, rsp_equal, busy} !== 21'b0) begin
            n_fail++;
            $display("FAIL rst_exec_out: got d=%h v=%b%b z=%b e=%b busy=%b want all 0",
                     rsp_data, rsp0_valid, rsp1_valid, rsp_zero, rsp_equal, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
                n_fail++; $display("FAIL rst_exec_quiet%0d: got %b want 000", k, {rsp0_valid, rsp1_valid, busy});
            end
        end
        drive_req(0, 1'b1, 3'd0, 16'h0, 16'h0);
        drive_req(1, 1'b1, 3'd0, 16'h0, 16'h0);
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL rst_exec_pri: got %b want 10", {req0_ready, req1_ready});
        end
        drive_req(0, 1'b0, 3'd0, 16'h0, 16'h0);
        drive_req(1, 1'b0, 3'd0, 16'h0, 16'h0);
        tick();

        // Reset while a response is being presented.
        drive_req(0, 1'b1, 3'd1, 16'h0000, 16'h00F0);
        tick();
        drive_req(0, 1'b0, 3'd1, 16'h0000, 16'h00F0);
        tick();
        n_tests++;
        if ({rsp0_valid, rsp_data} !== {1'b1, 16'h00F0}) begin
            n_fail++; $display("FAIL rst_resp_pre: got v=%b d=%h want v=1 d=00f0", rsp0_valid, rsp_data);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rsp_data, rsp0_valid, rsp1_valid, rsp_zero, rsp_equal, busy} !== 21'b0) begin
            n_fail++;
            $display("FAIL rst_resp_out: got d=%h v=%b%b z=%b e=%b busy=%b want all 0",
                     rsp_data, rsp0_valid, rsp1_valid, rsp_zero, rsp_equal, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
                n_fail++; $display("FAIL rst_resp_quiet%0d: got %b want 000", k, {rsp0_valid, rsp1_valid, busy});
            end
        end
        drive_req(0, 1'b1, 3'd0, 16'h0, 16'h0);
        drive_req(1, 1'b1, 3'd0, 16'h0, 16'h0);
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL rst_resp_pri: got %b want 10", {req0_ready, req1_ready});
        end
        drive_req(0, 1'b0, 3'd0, 16'h0, 16'h0);
        drive_req(1, 1'b0, 3'd0, 16'h0, 16'h0);
        tick();
        mpri = 1'b0;
    endtask

    task automatic test_random();
        logic        pend [2];
        logic [2:0]  rop  [2];
        logic [15:0] ra   [2];
        logic [15:0] rb   [2];
        logic [15:0] exp;
        int          w, d;
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < 2; p++) begin
                pend[p] = 1'($urandom_range(0, 1));
                rop[p]  = 3'($urandom_range(0, 7));
                ra[p]   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
                rb[p]   = ($urandom_range(0, 3) == 0) ? ra[p] : 16'($urandom);
            end
            if (!pend[0] && !pend[1]) pend[$urandom_range(0, 1)] = 1'b1;
            while (pend[0] || pend[1]) begin
                for (int p = 0; p < 2; p++) drive_req(p, pend[p], rop[p], ra[p], rb[p]);
                #1;
                w = (pend[0] && pend[1]) ? int'(mpri) : (pend[0] ? 0 : 1);
                n_tests++;
                if ({req1_ready, req0_ready} !== ((w == 1) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL rnd_grant it%0d: ready1,0 got %b want port %0d", it, {req1_ready, req0_ready}, w);
                end
                tick();
                pend[w] = 1'b0;
                drive_req(w, 1'b0, rop[w], ra[w], rb[w]);
                mpri = (w == 0);
                exp = ref_alu(rop[w], ra[w], rb[w]);
                d = $urandom_range(0, 3);
                if (d == 0) set_rsp_ready(w, 1'b1);
                set_rsp_ready(1 - w, 1'($urandom_range(0, 1)));
                tick();
                n_tests++;
                if ({rsp1_valid, rsp0_valid, rsp_data, rsp_zero, rsp_equal} !==
                    {(w == 1) ? 2'b10 : 2'b01, exp, exp == 16'h0, ra[w] == rb[w]}) begin
                    n_fail++;
                    $display("FAIL rnd_rsp it%0d: got v=%b%b d=%h z=%b e=%b want port %0d d=%h z=%b e=%b",
                             it, rsp1_valid, rsp0_valid, rsp_data, rsp_zero, rsp_equal,
                             w, exp, exp == 16'h0, ra[w] == rb[w]);
                end
                for (int k = 0; k < d; k++) begin
                    tick();
                    n_tests++;
                    if (port_rsp(w) !== 1'b1 || rsp_data !== exp) begin
                        n_fail++;
                        $display("FAIL rnd_hold it%0d: got v=%b d=%h want v=1 d=%h", it, port_rsp(w), rsp_data, exp);
                    end
                end
                if (d > 0) set_rsp_ready(w, 1'b1);
                tick();
                rsp0_ready = 1'b0;
                rsp1_ready = 1'b0;
                n_tests++;
                if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
                    n_fail++; $display("FAIL rnd_done it%0d: got %b want 000", it, {rsp0_valid, rsp1_valid, busy});
                end
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_edge_ops();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
